hilo_mdu_param: RTL and testbench



---
 rtl/hilo_mdu_param.sv | 218 +++++++++++++++++++++
 tb/tb_hilo_mdu_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_param.sv
// Multiply/divide unit with architectural HI/LO, fixed-latency long ops and flush.
// Define HILO_MDU_MACC_EN to enable madd/maddu/msub/msubu.
module hilo_mdu_param #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef HILO_MDU_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam int unsigned DW         = 2 * WIDTH;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi_r, lo_r, temp_hi, temp_lo;
  logic [CNT_W-1:0]   counter;
  logic               busy_r;
  logic               is_long, is_div;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               issue, commit, abort, mt_write;

  // Full-width products; truncation of the 2W x 2W product gives the exact 2W result
  logic [DW-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign a_zx   = {{WIDTH{1'b0}}, a_i};
  assign b_zx   = {{WIDTH{1'b0}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide on magnitudes; divisor forced nonzero so the datapath never divides by 0
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, b_safe_s, b_safe_u;
  logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg    = a_i[WIDTH-1];
  assign b_neg    = b_i[WIDTH-1];
  assign abs_a    = a_neg ? (~a_i + ONE) : a_i;
  assign abs_b    = b_neg ? (~b_i + ONE) : b_i;
  assign div_zero = (b_i == '0);
  assign div_ovf  = (a_i == INT_MIN) && (b_i == '1);
  assign b_safe_s = div_zero ? ONE : abs_b;
  assign b_safe_u = div_zero ? ONE : b_i;
  assign q_mag    = abs_a / b_safe_s;
  assign r_mag    = abs_a % b_safe_s;
  assign q_s      = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
  assign r_s      = a_neg ? (~r_mag + ONE) : r_mag;
  assign q_u      = a_i / b_safe_u;
  assign r_u      = a_i % b_safe_u;

  // Opcode decode and result selection at issue
  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    res_hi  = hi_r;
    res_lo  = lo_r;
    case (op_i)
      OP_MULT: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (div_zero) begin
          res_lo = '1;
          res_hi = a_i;
        end else if (div_ovf) begin
          res_lo = a_i;
          res_hi = '0;
        end else begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      OP_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (div_zero) begin
          res_lo = '1;
          res_hi = a_i;
        end else begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
`ifdef HILO_MDU_MACC_EN
      OP_MADD: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = {hi_r, lo_r} + prod_s;
      end
      OP_MADDU: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = {hi_r, lo_r} + prod_u;
      end
      OP_MSUB: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = {hi_r, lo_r} - prod_s;
      end
      OP_MSUBU: begin
        is_long          = 1'b1;
        {res_hi, res_lo} = {hi_r, lo_r} - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and control strobes; cancel wins over commit
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    mt_write  = 1'b0;
    case (state)
      IDLE: begin
        if (!cancel_i) begin
          if (is_long) begin
            issue     = 1'b1;
            state_nxt = RUN;
          end else if (op_i == OP_MTHI || op_i == OP_MTLO) begin
            mt_write = 1'b1;
          end
        end
      end
      RUN: begin
        if (cancel_i) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (counter == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Datapath: HI/LO, staged result, latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r    <= '0;
      lo_r    <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      counter <= '0;
      busy_r  <= 1'b0;
    end else begin
      if (issue) begin
        temp_hi <= res_hi;
        temp_lo <= res_lo;
        counter <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        busy_r  <= 1'b1;
      end else if (abort || commit) begin
        counter <= '0;
        busy_r  <= 1'b0;
      end else if (state == RUN) begin
        counter <= counter - CNT_W'(1);
      end
      if (commit) begin
        hi_r <= temp_hi;
        lo_r <= temp_lo;
      end
      if (mt_write && op_i == OP_MTHI) hi_r <= a_i;
      if (mt_write && op_i == OP_MTLO) lo_r <= a_i;
    end
  end

  assign busy_o = busy_r | (is_long & ~cancel_i);
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

  // Register read port; no forwarding of in-flight results
  always_comb begin
    rdata_o = '0;
    if (op_i == OP_MFHI)      rdata_o = hi_r;
    else if (op_i == OP_MFLO) rdata_o = lo_r;
  end

endmodule

// File: tb/tb_hilo_mdu_param.sv
// Directed bench for hilo_mdu_param: vector table plus flush, reset and MACC sequences.
module tb_hilo_mdu_param;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8, MADDU = 4'd10;

  logic        clk, reset, cancel_i, busy_o;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i, rdata_o, hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_i(op_i), .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i),
    .busy_o(busy_o), .rdata_o(rdata_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op for a single cycle, then count cycles with busy_o high (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    int guard;
    busy_cycles = 0;
    guard = 0;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; cancel_i = 1'b0;
    #1;
    if (busy_o) busy_cycles++;
    do begin
      @(negedge clk);
      op_i = NONE;
      #1;
      if (busy_o) busy_cycles++;
      guard++;
    end while (busy_o && guard < 100);
  endtask

  task automatic check_rdata(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    op_i = MFHI; #1;
    check({tag, " mfhi"}, rdata_o, exp_hi);
    op_i = MFLO; #1;
    check({tag, " mflo"}, rdata_o, exp_lo);
    op_i = NONE; #1;
  endtask

  initial begin
    int bc;
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 6};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6};
    vecs[2]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       11};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 11};
    vecs[4]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 11};
    vecs[5]  = '{DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 11};
    vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 11};
    vecs[7]  = '{DIVU,  32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 11};
    vecs[8]  = '{MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0,        6};
    vecs[9]  = '{MULT,  32'd2,        32'd3,        32'd0,        32'd6,        6};
    vecs[10] = '{MTHI,  32'h1234,     32'd0,        32'h1234,     32'd6,        0};
    vecs[11] = '{MTLO,  32'hABCD,     32'd0,        32'h1234,     32'hABCD,     0};
    vecs[12] = '{4'd15, 32'h5555,     32'h7777,     32'h1234,     32'hABCD,     0};
    vecs[13] = '{MFHI,  32'h9999,     32'd0,        32'h1234,     32'hABCD,     0};

    reset = 1'b1; op_i = NONE; a_i = '0; b_i = '0; cancel_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    check("reset rdata", rdata_o, 32'd0);
    check_rdata("reset", 32'd0, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
      check($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(vecs[i].busy));
      check($sformatf("vec%0d hi", i), hi_o, vecs[i].hi);
      check($sformatf("vec%0d lo", i), lo_o, vecs[i].lo);
      check_rdata($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end

    // Cancel in cycle t+3 of a mult: busy drops from t+4, HI/LO never update
    @(negedge clk);
    op_i = MULT; a_i = 32'd2; b_i = 32'd3; #1;
    check("cancel_run busy t", 32'(busy_o), 32'd1);
    @(negedge clk); op_i = NONE;
    @(negedge clk);
    @(negedge clk); cancel_i = 1'b1; #1;
    check("cancel_run busy t+3", 32'(busy_o), 32'd1);
    @(negedge clk); cancel_i = 1'b0; #1;
    check("cancel_run busy t+4", 32'(busy_o), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("cancel_run hi", hi_o, 32'h1234);
    check("cancel_run lo", lo_o, 32'hABCD);

    // Cancel coincident with issue and with mthi
    @(negedge clk);
    op_i = DIVU; a_i = 32'd9; b_i = 32'd2; cancel_i = 1'b1; #1;
    check("cancel_issue busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    op_i = MTHI; a_i = 32'hFFFF0000; #1;
    @(negedge clk);
    op_i = NONE; cancel_i = 1'b0; #1;
    check("cancel_issue busy next", 32'(busy_o), 32'd0);
    check("cancel_issue hi", hi_o, 32'h1234);
    check("cancel_issue lo", lo_o, 32'hABCD);

    // mthi presented mid-run is ignored; divide result still commits
    @(negedge clk);
    op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk); op_i = NONE;
    @(negedge clk); op_i = MTHI; a_i = 32'hDEAD; #1;
    check("run_ignore busy", 32'(busy_o), 32'd1);
    @(negedge clk); op_i = NONE;
    repeat (9) @(negedge clk);
    #1;
    check("run_ignore busy done", 32'(busy_o), 32'd0);
    check("run_ignore hi", hi_o, 32'd2);
    check("run_ignore lo", lo_o, 32'd14);

    // Reset in cycle t+2 of a div clears HI/LO and busy, and nothing commits later
    @(negedge clk);
    op_i = DIV; a_i = 32'd50; b_i = 32'd3;
    @(negedge clk); op_i = NONE;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("reset_mid busy", 32'(busy_o), 32'd0);
    check("reset_mid hi", hi_o, 32'd0);
    check("reset_mid lo", lo_o, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("reset_mid lo later", lo_o, 32'd0);
    check("reset_mid hi later", hi_o, 32'd0);

    // Accumulate: {0, FFFFFFFF} + 1*1
    run_op(MTHI, 32'd0, 32'd0, bc);
    run_op(MTLO, 32'hFFFFFFFF, 32'd0, bc);
    run_op(MADDU, 32'd1, 32'd1, bc);
`ifdef HILO_MDU_MACC_EN
    check("maddu busy_cycles", 32'(bc), 32'd6);
    check("maddu hi", hi_o, 32'd1);
    check("maddu lo", lo_o, 32'd0);
`else
    check("maddu busy_cycles", 32'(bc), 32'd0);
    check("maddu hi", hi_o, 32'd0);
    check("maddu lo", lo_o, 32'hFFFFFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
